seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4, sets clock cycles per digit slot (range 2..65535).
REQ-002 Parameter DEB_CNT, default 3, sets consecutive synchronized-high cycles needed to qualify a button press (range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 btn  input  1  raw asynchronous push-button; each qualified press toggles display blanking.
REQ-006 data_in  input  32  eight hex nibbles; nibble i (bits 4i+3:4i) maps to digit i.
REQ-007 data_vld  input  1  host write strobe; qualified by data_rdy.
REQ-008 data_rdy  output  1  high when the shadow register is empty and can accept a write.
REQ-009 seg_data  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-010 seg_sel  output  8  digit select, one-hot, active-high, registered.

Function
REQ-011 Scan divider counts 0..SCAN_DIV-1 and wraps; the digit index (0..7) advances by 1 on divider wrap, and 7 wraps to 0.
REQ-012 seg_sel SHALL equal one-hot(index) and seg_data SHALL equal hex-decode(disp nibble[index]), both registered, one cycle after the index value; dp is always 0.
REQ-013 Hex decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-014 Write handshake: data_vld=1 while data_rdy=1 loads data_in into shadow, and data_rdy drops the next cycle; data_vld while data_rdy=0 is ignored, with no state change.
REQ-015 Frame end is index=7 with divider=SCAN_DIV-1; at frame end, a full shadow is copied to disp and emptied, and data_rdy rises the next cycle.
REQ-016 A write accepted in the same cycle as frame end goes to shadow only; it commits at the following frame end and never bypasses to disp.
REQ-017 The disp register changes only at frame end, giving a tear-free display.
REQ-018 btn passes through a 2-flop synchronizer; the debounce counter increments while the synchronized btn is 1, saturating at DEB_CNT, and clears to 0 when the synchronized btn is 0.
REQ-019 Press event occurs on the edge where the debounce counter goes DEB_CNT-1 -> DEB_CNT; the blank register toggles on that same edge; one press yields exactly one toggle regardless of hold time.
REQ-020 While blank=1, seg_sel=00 and seg_data=00; the divider, index, handshake and commit continue unaffected.
REQ-021 Glitches shorter than DEB_CNT synchronized cycles produce no toggle.

Reset
REQ-022 With rst=0 at a rising edge: seg_sel=00, seg_data=00, data_rdy=1, shadow empty, disp=00000000, divider=0, index=0, blank=0, synchronizer=0, debounce counter=0.
REQ-023 Reset mid-frame or mid-press discards the pending shadow and partial debounce, with no toggle or commit.
REQ-024 On the first edge after rst returns to 1, seg_sel=01 and seg_data=3F.

Verification (SCAN_DIV=4, DEB_CNT=3, 10 ns clock)
REQ-025 Reset release with no writes -> seg_sel cycles 01,02,04,...,80,01, 4 cycles each, and seg_data stays 3F.
REQ-026 Write 87654321 mid-frame -> data_rdy low the next cycle; display unchanged until frame end; next frame shows 06 on sel 01 through 7F on sel 80; data_rdy high again.
REQ-027 Second write while data_rdy=0 -> ignored; a write coinciding with frame end commits one frame later, not immediately.
REQ-028 btn high for 4 cycles -> seg_sel=00 from the 5th edge after the first sampling edge; repeat 4-cycle press -> display resumes; 21 alternating 40 ns pulses -> final state blanked.
REQ-029 btn high for 2 cycles -> no toggle; btn held 100 cycles -> exactly one toggle.
REQ-030 Reset asserted during a debounce count with a shadow pending -> all outputs match REQ-022; no toggle and no commit afterwards.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Host write channel for the eight-digit seven-segment scan controller.
//
// Signals:
//   data_in   [31:0]  eight hex nibbles, nibble i (bits 4i+3:4i) -> digit i
//   data_vld          host write strobe, only taken while data_rdy is high
//   data_rdy          controller can accept a write (shadow register empty)
//
// Modports:
//   master  host side (drives data_in / data_vld, watches data_rdy)
//   slave   controller side
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
   logic [31:0] data_in;
   logic        data_vld;
   logic        data_rdy;

   modport master (
      output data_in,
      output data_vld,
      input  data_rdy
   );

   modport slave (
      input  data_in,
      input  data_vld,
      output data_rdy
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed driver for an eight-digit common-select seven-segment
// display. A host loads a 32-bit hex word into a shadow register; the word is
// moved into the display register only at the end of a full scan frame, so a
// frame never shows a mix of old and new digits. A debounced push-button
// toggles display blanking.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays selected (2..65535)
//   DEB_CNT   synchronized-high cycles that qualify a button press (1..255)
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous reset, active low
//   btn       raw asynchronous push-button
//   host      write channel (data_in / data_vld / data_rdy), slave side
//   seg_data  registered segment pattern {dp,g,f,e,d,c,b,a}, active high
//   seg_sel   registered one-hot digit select, active high
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 4,
   parameter int DEB_CNT  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn,
   seg_scan_ctrl_if.slave        host,
   output logic [7:0]            seg_data,
   output logic [7:0]            seg_sel
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DEB_MAX  = 8'(DEB_CNT);
   localparam logic [7:0]  DEB_PRE  = 8'(DEB_CNT - 1);

   logic [15:0] div_cnt;
   logic [2:0]  digit_idx;
   logic [31:0] shadow;
   logic        shadow_full;
   logic [31:0] disp;
   logic [1:0]  btn_sync;
   logic [7:0]  deb_cnt;
   logic        blank;
   logic        div_wrap;
   logic        frame_end;
   logic        write_acc;
   logic [3:0]  cur_nibble;

   // Hex digit to {g,f,e,d,c,b,a}; lower-case b and d keep them distinct
   // from 8 and 0.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   assign div_wrap      = (div_cnt == DIV_LAST);
   assign frame_end     = div_wrap && (digit_idx == 3'd7);
   assign host.data_rdy = ~shadow_full;
   assign write_acc     = host.data_vld && !shadow_full;
   assign cur_nibble    = disp[{digit_idx, 2'b00} +: 4];

   // Scan timing: the divider sets how long each digit is lit, and the
   // three-bit digit index wraps from 7 back to 0 on its own.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt   <= '0;
         digit_idx <= '0;
      end else if (div_wrap) begin
         div_cnt   <= '0;
         digit_idx <= digit_idx + 3'd1;
      end else begin
         div_cnt   <= div_cnt + 16'd1;
      end
   end

   // Double buffering: a write can only land in an empty shadow, and a full
   // shadow can only drain at frame end. The two cases are mutually
   // exclusive, so a write taken on the frame-end cycle simply waits in the
   // shadow for the next frame end instead of reaching disp early.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow      <= '0;
         shadow_full <= 1'b0;
         disp        <= '0;
      end else if (write_acc) begin
         shadow      <= host.data_in;
         shadow_full <= 1'b1;
      end else if (frame_end && shadow_full) begin
         disp        <= shadow;
         shadow_full <= 1'b0;
      end
   end

   // Button path: two flops tame metastability, then a saturating counter
   // needs DEB_CNT consecutive high samples. Blanking flips only on the
   // single edge where the counter reaches DEB_CNT, so holding the button
   // gives one toggle and short glitches give none.
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_sync <= '0;
         deb_cnt  <= '0;
         blank    <= 1'b0;
      end else begin
         btn_sync <= {btn_sync[0], btn};
         if (btn_sync[1]) begin
            if (deb_cnt != DEB_MAX) begin
               deb_cnt <= deb_cnt + 8'd1;
            end
            if (deb_cnt == DEB_PRE) begin
               blank <= ~blank;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Output stage: registers the select and pattern for the current index,
   // so the pins trail the index by one cycle. Blanking only forces the
   // pins low; scanning and buffering keep running underneath.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_sel  <= '0;
         seg_data <= '0;
      end else if (blank) begin
         seg_sel  <= '0;
         seg_data <= '0;
      end else begin
         seg_sel  <= 8'b0000_0001 << digit_idx;
         seg_data <= {1'b0, hex_decode(cur_nibble)};
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl (SCAN_DIV=4, DEB_CNT=3, 10 ns clock).
// The stimulus process drives one vector per clock and queues the outputs
// expected right after that edge; a monitor on the falling edge pops and
// compares whatever is due, independently of the stimulus.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic [7:0] seg_data;
   logic [7:0] seg_sel;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .SCAN_DIV (4),
      .DEB_CNT  (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .host     (bus),
      .seg_data (seg_data),
      .seg_sel  (seg_sel)
   );

   typedef struct {
      int unsigned edge_no;
      string       name;
      logic [7:0]  sel;
      logic [7:0]  seg;
      logic        rdy;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned edge_cnt = 0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          toggle_vis [0:1023];
   bit          exp_blank;

   // Patterns for 87654321: digit i shows nibble value i+1.
   localparam logic [7:0] PAT_A [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F};

   // 100 MHz clock, first rising edge at 5 ns.
   initial forever #5 clk = ~clk;

   // Edge counter lets queued expectations name the edge they belong to.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input exp_t e);
      n_vec++;
      if (e.edge_no != edge_cnt || seg_sel !== e.sel || seg_data !== e.seg ||
          bus.data_rdy !== e.rdy) begin
         n_err++;
         $display("[TB] FAIL %s edge %0d (at %0d): sel=%h seg=%h rdy=%b, expected sel=%h seg=%h rdy=%b",
                  e.name, e.edge_no, edge_cnt, seg_sel, seg_data, bus.data_rdy,
                  e.sel, e.seg, e.rdy);
      end
   endtask

   // Monitor: compare every expectation that has come due at this edge.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
         mon_e = sb_q.pop_front();
         checkOutput(mon_e);
      end
   end

   task automatic applyStimulus(input logic rst_v, input logic vld_v,
                                input logic [31:0] data_v, input logic btn_v,
                                input string name, input logic [7:0] sel_e,
                                input logic [7:0] seg_e, input logic rdy_e);
      exp_t e;
      rst          = rst_v;
      bus.data_vld = vld_v;
      bus.data_in  = data_v;
      btn          = btn_v;
      e.edge_no    = edge_cnt + 1;
      e.name       = name;
      e.sel        = sel_e;
      e.seg        = seg_e;
      e.rdy        = rdy_e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // k counts edges from reset release; index before edge k is (k/4)%8.
   function automatic logic [7:0] scan_sel(input int k);
      return 8'(1 << ((k / 4) % 8));
   endfunction

   // Frames 0-1 show zeros, 2-3 show 87654321, later frames 22222222.
   function automatic logic [7:0] frame_seg(input int k);
      int f;
      f = k / 32;
      if (f < 2)      return 8'h3F;
      else if (f < 4) return PAT_A[(k / 4) % 8];
      else            return 8'h5B;
   endfunction

   function automatic logic rdy_at(input int k);
      if (k < 40)       return 1'b1;
      else if (k < 63)  return 1'b0;
      else if (k < 95)  return 1'b1;
      else if (k < 127) return 1'b0;
      else if (k < 560) return 1'b1;
      else              return 1'b0;
   endfunction

   function automatic logic btn_at(input int k);
      if (k >= 170 && k <= 173) return 1'b1;
      if (k >= 190 && k <= 193) return 1'b1;
      if (k >= 210 && k <= 211) return 1'b1;
      if (k >= 230 && k <= 329) return 1'b1;
      if (k >= 340 && k <= 343) return 1'b1;
      if (k >= 360 && k < 528 && ((k - 360) % 8) < 4) return 1'b1;
      if (k >= 562) return 1'b1;
      return 1'b0;
   endfunction

   function automatic string label_of(input int k);
      if (k < 40)       return "scan_idle";
      else if (k < 64)  return "write_pending";
      else if (k < 95)  return "frame_a";
      else if (k < 128) return "coincident_write";
      else if (k < 165) return "frame_b";
      else if (k < 560) return "button";
      else              return "press_with_pending";
   endfunction

   initial begin
      logic        vld_v;
      logic [31:0] d_v;
      logic [7:0]  sel_e;
      logic [7:0]  seg_e;

      // Press start s (first sampling edge) shows blanking change from edge
      // s+5: two synchronizer edges, three counting edges, one output edge.
      // The 2-cycle press at 210 never reaches the threshold.
      toggle_vis[175] = 1'b1;
      toggle_vis[195] = 1'b1;
      toggle_vis[235] = 1'b1;
      toggle_vis[345] = 1'b1;
      for (int j = 0; j < 21; j++) toggle_vis[365 + 8 * j] = 1'b1;
      exp_blank = 1'b0;

      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, "reset", 8'h00, 8'h00, 1'b1);

      for (int k = 0; k < 566; k++) begin
         exp_blank ^= toggle_vis[k];
         vld_v = 1'b0;
         d_v   = 32'h0;
         case (k)
            40:  begin vld_v = 1'b1; d_v = 32'h8765_4321; end
            50:  begin vld_v = 1'b1; d_v = 32'hDEAD_BEEF; end
            95:  begin vld_v = 1'b1; d_v = 32'h2222_2222; end
            560: begin vld_v = 1'b1; d_v = 32'h3333_3333; end
            default: ;
         endcase
         sel_e = exp_blank ? 8'h00 : scan_sel(k);
         seg_e = exp_blank ? 8'h00 : frame_seg(k);
         applyStimulus(1'b1, vld_v, d_v, btn_at(k), label_of(k), sel_e, seg_e, rdy_at(k));
      end

      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, "reset_mid_press", 8'h00, 8'h00, 1'b1);

      for (int k = 0; k < 70; k++)
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, "post_reset", scan_sel(k), 8'h3F, 1'b1);

      @(negedge clk);
      #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
